// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Summary  : RISC-V fetch stage: req/gnt/rsp imem port, PC-tagged instr buffer.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic        redirect_sel,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imm_ext,
    input  logic [31:0] alu_result,
    output logic        fetch_err
);

    localparam int          c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          c_cnt_w = c_ptr_w + 1;
    localparam logic [31:0] c_nop   = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t              r_state;
    logic [31:0]         r_fpc;
    logic                r_out;
    logic                r_discard;
    logic                r_err;
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [31:0]         r_mem_instr [FIFO_DEPTH];
    logic [31:0]         r_mem_pc    [FIFO_DEPTH];

    logic [31:0]         w_target;
    logic                w_misaligned;
    logic                w_gnt_now;
    logic                w_rsp_now;
    logic                w_out_after;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_slot_free;

    assign w_target     = redirect_sel ? (alu_result & 32'hFFFF_FFFE) : (redirect_pc + imm_ext);
    assign w_misaligned = w_target[1];
    assign w_gnt_now    = (r_state == S_REQ) && imem_gnt;
    assign w_rsp_now    = r_out && imem_rvalid;
    // A response still owed after this edge must be drained before the next request.
    assign w_out_after  = (r_out && !imem_rvalid) || w_gnt_now;
    assign w_empty      = (r_count == '0);
    assign w_push       = w_rsp_now && !r_discard && !redirect;
    assign w_pop        = !w_empty && instr_ready && !redirect;
    assign w_slot_free  = (int'(r_count) + int'(r_out)) < FIFO_DEPTH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_fpc     <= RESET_PC;
            r_out     <= 1'b0;
            r_discard <= 1'b0;
            r_err     <= 1'b0;
        end else if (redirect) begin
            r_fpc     <= w_target;
            r_err     <= w_misaligned;
            r_out     <= w_out_after;
            r_discard <= w_out_after;
            if (w_misaligned) begin
                r_state <= S_HALT;
            end else if (w_out_after) begin
                r_state <= S_RSP;
            end else begin
                r_state <= S_REQ;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_slot_free) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (imem_gnt) begin
                        r_fpc   <= r_fpc + 32'd4;
                        r_out   <= 1'b1;
                        r_state <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (imem_rvalid) begin
                        r_out     <= 1'b0;
                        r_discard <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                S_HALT: begin
                    if (w_rsp_now) begin
                        r_out     <= 1'b0;
                        r_discard <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // fpc already advanced past the granted word, so its PC is fpc - 4.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]    <= r_fpc - 32'd4;
        end
    end

    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_fpc;
    assign instr_valid = !w_empty;
    assign instr       = w_empty ? c_nop : r_mem_instr[r_rd_ptr];
    assign instr_pc    = w_empty ? 32'd0 : r_mem_pc[r_rd_ptr];
    assign instr_pc4   = instr_pc + 32'd4;
    assign fetch_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Summary  : Directed + randomized bench for fetch_unit against a queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic        redirect_sel = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imm_ext = '0;
    logic [31:0] alu_result = '0;
    logic        fetch_err;

    fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_pc4    (instr_pc4),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .redirect     (redirect),
        .redirect_sel (redirect_sel),
        .redirect_pc  (redirect_pc),
        .imm_ext      (imm_ext),
        .alu_result   (alu_result),
        .fetch_err    (fetch_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: instruction buffer as a queue of {pc, word}, one outstanding fetch.
    logic [63:0] m_q[$];
    logic [31:0] m_fpc;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    bit          m_out;
    bit          m_stale;
    bit          m_err;
    int          m_lat;
    int          idle_run;
    int          n_req;
    int          n_gnt;
    bit          fixed_en = 1'b0;
    logic [31:0] fixed_word = 32'h0050_0093;
    bit          hit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fpc    = RST_PC;
        m_out    = 1'b0;
        m_stale  = 1'b0;
        m_err    = 1'b0;
        m_lat    = 0;
        idle_run = 0;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req",   32'(imem_req), 32'd0);
        check("rst_addr",  imem_addr, RST_PC);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_pc",    instr_pc, 32'd0);
        check("rst_err",   32'(fetch_err), 32'd0);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock: check outputs at negedge, drive inputs, advance the model at posedge.
    task automatic step(input bit redir, input bit rsel, input logic [31:0] rpc,
                        input logic [31:0] imm, input logic [31:0] alu,
                        input int gnt_pct, input int rdy_pct, input int lat_max);
        logic        s_req;
        logic        g;
        logic        rv;
        logic        rdy;
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        s_req = imem_req;
        check("valid", 32'(instr_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("instr", instr, m_q[0][31:0]);
            exp_pc = m_q[0][63:32];
        end else begin
            check("instr", instr, NOP);
            exp_pc = 32'd0;
        end
        check("pc", instr_pc, exp_pc);
        check("pc4", instr_pc4, exp_pc + 32'd4);
        check("err", 32'(fetch_err), 32'(m_err));
        if (m_err || m_out || m_q.size() >= DEPTH) check("req_block", 32'(s_req), 32'd0);
        if (s_req) check("addr", imem_addr, m_fpc);
        if (!m_err && !m_out && m_q.size() < DEPTH && !s_req) idle_run++;
        else idle_run = 0;
        check("idle_run", 32'(idle_run > 2), 32'd0);
        if (s_req) n_req++;

        g   = s_req && ($urandom_range(99) < gnt_pct);
        rv  = m_out && (m_lat == 0);
        if (m_out && m_lat != 0) m_lat--;
        rdy = ($urandom_range(99) < rdy_pct);
        if (g) n_gnt++;
        imem_gnt     = g;
        imem_rvalid  = rv;
        imem_rdata   = rv ? m_data : $urandom();
        instr_ready  = rdy;
        redirect     = redir;
        redirect_sel = rsel;
        redirect_pc  = rpc;
        imm_ext      = imm;
        alu_result   = alu;
        @(posedge clk);

        if (redir) begin
            tgt = rsel ? {alu[31:1], 1'b0} : (rpc + imm);
            m_q.delete();
            if (rv) m_out = 1'b0;
            if (g) begin
                m_out  = 1'b1;
                m_lat  = $urandom_range(lat_max, 0);
                m_data = $urandom();
            end
            if (m_out) m_stale = 1'b1;
            m_fpc = tgt;
            m_err = tgt[1];
        end else begin
            if (rdy && m_q.size() != 0) void'(m_q.pop_front());
            if (rv) begin
                if (!m_stale) m_q.push_back({m_addr, m_data});
                m_out = 1'b0;
            end
            if (g) begin
                m_addr  = m_fpc;
                m_fpc   = m_fpc + 32'd4;
                m_out   = 1'b1;
                m_stale = 1'b0;
                m_lat   = $urandom_range(lat_max, 0);
                m_data  = fixed_en ? fixed_word : $urandom();
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int gnt_pct, input int rdy_pct, input int lat_max);
        step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, gnt_pct, rdy_pct, lat_max);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // Full-rate fetch: one grant every 3 cycles, first request in cycle 1.
        do_reset();
        fixed_en = 1'b1;
        check("req_c0", 32'(imem_req), 32'd0);
        n_gnt = 0;
        idle(100, 100, 0);
        check("req_c1", 32'(imem_req), 32'd1);
        check("addr_c1", imem_addr, 32'h0);
        repeat (11) idle(100, 100, 0);
        check("throughput", 32'(n_gnt), 32'd4);

        // Decode stalled: exactly two words buffered, no third request.
        do_reset();
        repeat (14) idle(100, 0, 0);
        n_req = 0;
        repeat (10) idle(100, 0, 0);
        check("no_3rd_req", 32'(n_req), 32'd0);
        check("hold_pc0", instr_pc, 32'h0);
        check("hold_instr", instr, 32'h0050_0093);
        idle(100, 100, 0);
        check("drain_pc1", instr_pc, 32'h4);
        repeat (4) idle(100, 100, 0);
        fixed_en = 1'b0;

        // Branch redirect while a response is pending.
        do_reset();
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (m_out) hit = 1'b1;
            else idle(100, 100, 2);
        end
        check("br_wait_rsp", 32'(hit), 32'd1);
        step(1'b1, 1'b0, 32'h10, 32'hFFFF_FFF8, 32'd0, 100, 100, 2);
        check("br_flush", 32'(instr_valid), 32'd0);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (instr_valid) hit = 1'b1;
            else idle(100, 0, 2);
        end
        check("br_wait_valid", 32'(hit), 32'd1);
        check("br_head_pc", instr_pc, 32'h8);

        // JALR coincident with rvalid and a ready head entry.
        do_reset();
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (m_out && m_lat == 0 && m_q.size() == 1) hit = 1'b1;
            else idle(100, 0, 0);
        end
        check("jalr_wait", 32'(hit), 32'd1);
        step(1'b1, 1'b1, 32'd0, 32'd0, 32'h0000_0101, 0, 100, 0);
        check("jalr_flush", 32'(instr_valid), 32'd0);
        check("jalr_req", 32'(imem_req), 32'd1);
        check("jalr_addr", imem_addr, 32'h100);

        // Misaligned target halts fetch; an aligned redirect resumes.
        step(1'b1, 1'b1, 32'd0, 32'd0, 32'h0000_0102, 100, 50, 3);
        n_req = 0;
        repeat (20) idle(100, 50, 3);
        check("halt_noreq", 32'(n_req), 32'd0);
        check("halt_err", 32'(fetch_err), 32'd1);
        step(1'b1, 1'b1, 32'd0, 32'd0, 32'h0000_0200, 0, 50, 3);
        check("resume_err", 32'(fetch_err), 32'd0);
        check("resume_req", 32'(imem_req), 32'd1);
        check("resume_addr", imem_addr, 32'h200);
        repeat (10) idle(100, 50, 3);

        // Asynchronous reset mid-response with one buffered entry.
        do_reset();
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (m_out && m_q.size() == 1) hit = 1'b1;
            else idle(100, 0, 3);
        end
        check("arst_wait", 32'(hit), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", 32'(imem_req), 32'd0);
        check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_instr", instr, NOP);
        do_reset();
        idle(100, 100, 1);
        check("arst_restart_req", 32'(imem_req), 32'd1);
        check("arst_restart_addr", imem_addr, RST_PC);

        // Randomized traffic with occasional branches, jumps and misaligned targets.
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] rpc;
            logic [31:0] imm;
            logic [31:0] alu;
            bit          redir;
            bit          bad;
            redir = ($urandom_range(99) < 5);
            bad   = ($urandom_range(9) == 0);
            rpc   = $urandom() & 32'hFFFF_FFFC;
            imm   = $urandom() & 32'hFFFF_FFFC;
            alu   = $urandom();
            imm[1] = bad;
            alu[1] = bad;
            step(redir, 1'($urandom_range(1)), rpc, imm, alu,
                 (i < 2000) ? 70 : 100, (i % 1000 < 500) ? 60 : 20, 3);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage for the RISC-V core; sits directly upstream of decode and the immediate extender.
- Holds the fetch PC and fetches instruction words over a request/grant/response instruction-memory interface.
- Buffers fetched words with their PC in a small FIFO and presents them to decode with a valid/ready handshake.
- Consumes the extended immediate from the extender to compute branch/JAL targets; redirects from execute are absolute JALR targets.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset; must be word-aligned.
FIFO_DEPTH, 2, instruction buffer entries; power of two, at least 2.

Ports:
clk  in  1  core clock; all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
imem_req  out  1  fetch request.
imem_addr  out  32  word-aligned fetch address; stable while imem_req=1 and imem_gnt=0, except on redirect.
imem_gnt  in  1  request accepted this cycle.
imem_rvalid  in  1  read data valid; arrives at least 1 cycle after gnt.
imem_rdata  in  32  instruction word.
instr  out  32  FIFO head instruction; 32'h0000_0013 (NOP) when empty.
instr_pc  out  32  PC of head; 0 when empty.
instr_pc4  out  32  instr_pc + 4.
instr_valid  out  1  FIFO non-empty.
instr_ready  in  1  decode accepts head; pop when valid and ready.
redirect  in  1  taken branch or jump this cycle.
redirect_sel  in  1  0 = PC-relative target; 1 = absolute target.
redirect_pc  in  32  PC of the branch/JAL instruction.
imm_ext  in  32  sign-extended immediate from the extender.
alu_result  in  32  JALR target from the ALU.
fetch_err  out  1  sticky misaligned-target flag.

Behaviour:
- Reset (async, rst_n=0):
  - fpc=RESET_PC; FSM=IDLE; FIFO empty; outstanding=0; discard=0.
  - Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=NOP, instr_pc=0, fetch_err=0.
- Target calculation:
  - redirect_sel=0: target = redirect_pc + imm_ext, 32-bit wrap.
  - redirect_sel=1: target = {alu_result[31:1],1'b0}.
  - target[1]=1 is misaligned.
- Only one request outstanding at a time.
- FSM states:
  - IDLE: if slots free (FIFO count + outstanding < FIFO_DEPTH; a same-cycle pop is not credited), go to REQ. The request asserts on the cycle after entering REQ.
  - REQ: imem_req=1, imem_addr=fpc. On imem_gnt: fpc<=fpc+4 (wraps at 2^32), outstanding=1, go to RSP.
  - RSP: imem_req=0. On imem_rvalid: unless discard is set, push {imem_rdata, pc}; clear outstanding and discard; go to IDLE.
  - HALT: imem_req=0; left only via an aligned redirect.
- Timing:
  - First request is cycle 1 after rst_n rises.
  - Push on the rvalid edge; instr_valid is high the following cycle.
  - Peak throughput: one instruction per 3 cycles with gnt=1 and rvalid one cycle after gnt.
- Redirect has highest priority and is registered the same edge:
  - FIFO flushed; a same-cycle pop is ignored; instr_valid=0 next cycle.
  - fpc<=target.
  - From IDLE or REQ: next state REQ with the new address; a withdrawn ungranted request is allowed. If gnt coincides with redirect, the grant is treated as outstanding and discard is set.
  - From RSP: discard<=1; stay in RSP; the pending response is dropped, then the target is fetched.
  - redirect and rvalid in the same cycle: response dropped; next state REQ with target.
  - Misaligned target: fetch_err<=1; go to HALT (a pending response is still drained and discarded first). An aligned redirect clears fetch_err and resumes fetching.
- Full FIFO: no request issued; pending rvalid always has a reserved slot, so no overflow.
- Empty FIFO with instr_ready=1: no effect.
- Simultaneous push and pop: count unchanged; order preserved.

Test Plan:
- Reset release, gnt=1, rvalid one cycle after gnt, rdata=0x00500093, ready=1 -> imem_addr 0x0 then 0x4; instr_valid cycle after rvalid with instr=0x00500093, instr_pc=0x0, instr_pc4=0x4.
- instr_ready=0 held -> exactly FIFO_DEPTH=2 words buffered (pc 0x0, 0x4); no third imem_req; ready=1 drains both in order.
- Branch redirect at redirect_pc=0x10, imm_ext=0xFFFFFFF8, while in RSP -> pending response dropped; next request addr 0x8; FIFO empty until the 0x8 response arrives.
- JALR with alu_result=0x0000_0101, redirect coincident with rvalid and instr_ready -> response dropped; next imem_addr=0x100; no pop of stale head.
- Target 0x102 -> fetch_err=1, imem_req=0 indefinitely; then redirect to 0x200 -> fetch_err=0, request at 0x200.
- rst_n low mid-RSP with FIFO holding 1 entry -> immediate imem_req=0, instr_valid=0, instr=NOP; after release, fetch restarts at RESET_PC.
